// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx serializer.
// The PAR state exists only when PISO_TX_PARITY_EN is defined.
package piso_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
`ifdef PISO_TX_PARITY_EN
        StPar   = 2'd2,
`endif
        StDone  = 2'd3
    } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for piso_tx: counts 0..WIDTH-1 while enabled and flags
// the last position with tc.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with a one-cycle done pulse.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the LSB.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             sdata,
    output logic             svalid,
    output logic             done
);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             cnt_clear;
    logic             cnt_en;
    logic             cnt_tc;

`ifdef PISO_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        ready     = 1'b0;
        sdata     = 1'b0;
        svalid    = 1'b0;
        done      = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                ready     = 1'b1;
                cnt_clear = 1'b1;
                if (load) begin
                    shift_d = data_in;
                    state_d = StShift;
`ifdef PISO_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            StShift: begin
                svalid  = 1'b1;
                sdata   = shift_q[WIDTH-1];
                cnt_en  = 1'b1;
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                if (cnt_tc) begin
`ifdef PISO_TX_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            StPar: begin
                svalid  = 1'b1;
                sdata   = parity_q;
                state_d = StDone;
            end
`endif
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a queue-based transaction model checked every
// cycle, plus literal expectations for the directed scenarios (WIDTH 8 and 4).
module tb_piso_tx;

    localparam int W8 = 8;
    localparam int W4 = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       load8 = 1'b0;
    logic       load4 = 1'b0;
    logic [7:0] data8 = '0;
    logic [3:0] data4 = '0;

    logic ready8, sdata8, svalid8, done8;
    logic ready4, sdata4, svalid4, done4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .load    (load8),
        .data_in (data8),
        .ready   (ready8),
        .sdata   (sdata8),
        .svalid  (svalid8),
        .done    (done8)
    );

    piso_tx #(.WIDTH(W4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .load    (load4),
        .data_in (data4),
        .ready   (ready4),
        .sdata   (sdata4),
        .svalid  (svalid4),
        .done    (done4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each accepted word expands into its per-cycle output tuples
    // {ready, svalid, sdata, done}; an empty queue means idle.
    logic [3:0] q8[$];
    logic [3:0] q4[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q8.delete();
        end else if (q8.size() != 0) begin
            void'(q8.pop_front());
        end else if (load8) begin
            for (int i = W8 - 1; i >= 0; i--) q8.push_back({2'b01, data8[i], 1'b0});
            if (P == 1) q8.push_back({2'b01, ^data8, 1'b0});
            q8.push_back(4'b0001);
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q4.delete();
        end else if (q4.size() != 0) begin
            void'(q4.pop_front());
        end else if (load4) begin
            for (int i = W4 - 1; i >= 0; i--) q4.push_back({2'b01, data4[i], 1'b0});
            if (P == 1) q4.push_back({2'b01, ^data4, 1'b0});
            q4.push_back(4'b0001);
        end
    end

    always @(negedge clk) begin
        check("model_w8", {60'b0, ready8, svalid8, sdata8, done8},
              {60'b0, (q8.size() != 0) ? q8[0] : 4'b1000});
        check("model_w4", {60'b0, ready4, svalid4, sdata4, done4},
              {60'b0, (q4.size() != 0) ? q4[0] : 4'b1000});
    end

    // Serial stream and done-pulse monitor for the WIDTH=8 instance.
    logic bitq[$];
    int   ndone8 = 0;

    always @(negedge clk) begin
        if (svalid8) bitq.push_back(sdata8);
        if (done8) ndone8++;
    end

    function automatic logic [63:0] last_bits(input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], bitq[bitq.size() - n + i]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] d);
        data8 = d;
        load8 = 1'b1;
        tick();
        load8 = 1'b0;
    endtask

    int nd0;
    int nb0;
    logic [3:0] c4;

    initial begin
        #1 rst = 1'b0;
        tick();
        check("rst_ready", {63'b0, ready8}, 64'd1);
        check("rst_svalid", {63'b0, svalid8}, 64'd0);
        check("rst_done", {63'b0, done8}, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single word 0x55
        nd0 = ndone8;
        nb0 = bitq.size();
        send8(8'h55);
        check("t55_ready_low", {63'b0, ready8}, 64'd0);
        check("t55_first_bit", {62'b0, svalid8, sdata8}, 64'b10);
        repeat (W8 + P) tick();
        check("t55_done", {63'b0, done8}, 64'd1);
        tick();
        check("t55_ready_back", {63'b0, ready8}, 64'd1);
        check("t55_word", last_bits(W8 + P), (P == 1) ? 64'h0AA : 64'h55);
        check("t55_ndone", 64'(ndone8 - nd0), 64'd1);
        check("t55_nbits", 64'(bitq.size() - nb0), 64'(W8 + P));

        // Back-to-back 0xAA then 0xFF with load held
        tick();
        nd0 = ndone8;
        nb0 = bitq.size();
        data8 = 8'hAA;
        load8 = 1'b1;
        tick();
        data8 = 8'hFF;
        repeat (W8 + P + 2) tick();
        load8 = 1'b0;
        check("b2b_second_accepted", {63'b0, ready8}, 64'd0);
        repeat (W8 + P + 3) tick();
        check("b2b_ndone", 64'(ndone8 - nd0), 64'd2);
        check("b2b_nbits", 64'(bitq.size() - nb0), 64'(2 * (W8 + P)));
        check("b2b_stream", last_bits(2 * (W8 + P)), (P == 1) ? 64'h2A9FE : 64'hAAFF);

        // Load pulsed during the 3rd shift cycle is ignored
        tick();
        nd0 = ndone8;
        nb0 = bitq.size();
        send8(8'h55);
        tick();
        tick();
        data8 = 8'h00;
        load8 = 1'b1;
        tick();
        load8 = 1'b0;
        repeat (W8 + P + 4) tick();
        check("ign_word", last_bits(W8 + P), (P == 1) ? 64'h0AA : 64'h55);
        check("ign_ndone", 64'(ndone8 - nd0), 64'd1);
        check("ign_nbits", 64'(bitq.size() - nb0), 64'(W8 + P));

        // Reset in the 4th shift cycle aborts the word
        nd0 = ndone8;
        send8(8'h55);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("abort_outputs", {60'b0, ready8, svalid8, sdata8, done8}, 64'b1000);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("abort_no_done", 64'(ndone8 - nd0), 64'd0);
        nb0 = bitq.size();
        send8(8'hFF);
        repeat (W8 + P + 3) tick();
        check("post_rst_word", last_bits(W8 + P), (P == 1) ? 64'h1FE : 64'hFF);
        check("post_rst_ndone", 64'(ndone8 - nd0), 64'd1);
        check("post_rst_nbits", 64'(bitq.size() - nb0), 64'(W8 + P));

        // Parity patterns (plain data patterns when parity is absent)
        send8(8'h07);
        repeat (W8 + P + 2) tick();
        check("w07_word", last_bits(W8 + P), (P == 1) ? 64'h00F : 64'h07);
        send8(8'h03);
        repeat (W8 + P + 2) tick();
        check("w03_word", last_bits(W8 + P), (P == 1) ? 64'h006 : 64'h03);

        // WIDTH=4 instance, 0xC
        c4 = 4'hC;
        data4 = c4;
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
        check("w4_ready_low", {63'b0, ready4}, 64'd0);
        for (int i = 0; i < W4; i++) begin
            check("w4_bit", {62'b0, svalid4, sdata4}, {62'b0, 1'b1, c4[W4 - 1 - i]});
            tick();
        end
        if (P == 1) begin
            check("w4_parity", {62'b0, svalid4, sdata4}, 64'b10);
            tick();
        end
        check("w4_done", {62'b0, done4, svalid4}, 64'b10);
        tick();
        check("w4_ready_back", {63'b0, ready4}, 64'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
